// File: rtl/jt12_eg_pkg.sv
// Shared definitions for the envelope generator ring: state codes, the
// silent attenuation level, counter widths and the per-slot context entry.
package jt12_eg_pkg;

   localparam logic [2:0] ATTACK  = 3'b001;
   localparam logic [2:0] DECAY   = 3'b010;
   localparam logic [2:0] HOLD    = 3'b100;
   localparam logic [2:0] RELEASE = 3'b000;

   localparam logic [9:0] EG_SILENT = 10'h3FF;

   localparam int SLOT_W  = 5;
   localparam int EGCNT_W = 15;

   // One operator's envelope context as it travels around the ring
   typedef struct packed {
      logic [2:0] state;
      logic [9:0] eg;
      logic       inv;
      logic       lock;
      logic       cnt;
      logic       key;
   } eg_entry_t;

   localparam int ENTRY_W = $bits(eg_entry_t);

   localparam eg_entry_t ENTRY_RST = '{state: RELEASE, eg: EG_SILENT,
                                       inv: 1'b0, lock: 1'b0, cnt: 1'b0,
                                       key: 1'b0};

   // Anything that is not one of the three active one-hot codes is RELEASE
   function automatic logic [2:0] legal_state(input logic [2:0] s);
      case (s)
         ATTACK, DECAY, HOLD: return s;
         default:             return RELEASE;
      endcase
   endfunction

endpackage

// File: rtl/jt12_sh_rst.sv
// Enabled shift register with asynchronous reset to a fixed value. New data
// enters at the tail and reaches the head after STAGES enabled shifts.
module jt12_sh_rst #(
   parameter int                DATA_W  = 17,
   parameter int                STAGES  = 24,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic [DATA_W-1:0] tail,
   output logic [DATA_W-1:0] head
);

   logic [DATA_W-1:0] bits [STAGES];

   // Shift one position toward the head on every enabled clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) bits[i] <= RST_VAL;
      end else if (clk_en) begin
         for (int i = 0; i < STAGES-1; i++) bits[i] <= bits[i+1];
         bits[STAGES-1] <= tail;
      end
   end

   assign head = bits[0];

endmodule

// File: rtl/jt12_eg_ring.sv
// Envelope context ring for 24 operator slots. The head entry feeds the
// combinational envelope stage and its results are written back at the tail,
// so each slot sees its own updated context one full ring turn later. Also
// produces key edge pulses, the head slot index and the global eg counter.
module jt12_eg_ring
   import jt12_eg_pkg::*;
#(
   parameter int SLOTS   = 24,
   parameter int CNT_DIV = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk_en,
   input  logic                keyon_in,
   input  logic [2:0]          state_next,
   input  logic [9:0]          pure_eg_in,
   input  logic                ssg_inv_next,
   input  logic                ssg_lock_next,
   input  logic                cnt_lsb,
   output logic                keyon_now,
   output logic                keyoff_now,
   output logic [2:0]          state_in,
   output logic [9:0]          eg_in,
   output logic                ssg_inv_in,
   output logic                ssg_lock_in,
   output logic                cnt_in,
   output logic [EGCNT_W-1:0]  eg_cnt,
   output logic [SLOT_W-1:0]   slot,
   output logic                zero
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS-1);
   localparam int                DIV_W     = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CNT_DIV-1);

   eg_entry_t        head;
   eg_entry_t        tail;
   logic [DIV_W-1:0] div;
   logic             slot_wrap;

   // Pack the combinational stage results plus the current key for the tail
   always_comb begin
      tail.state = legal_state(state_next);
      tail.eg    = pure_eg_in;
      tail.inv   = ssg_inv_next;
      tail.lock  = ssg_lock_next;
      tail.cnt   = cnt_lsb;
      tail.key   = keyon_in;
   end

   jt12_sh_rst #(
      .DATA_W  (ENTRY_W),
      .STAGES  (SLOTS),
      .RST_VAL (ENTRY_RST)
   ) u_ring (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .tail   (tail),
      .head   (head)
   );

   assign state_in    = head.state;
   assign eg_in       = head.eg;
   assign ssg_inv_in  = head.inv;
   assign ssg_lock_in = head.lock;
   assign cnt_in      = head.cnt;

   // The key bit stored with the entry is the previous pass's key, so the
   // edge terms stay live with keyon_in even while clk_en is low
   assign keyon_now  = keyon_in & ~head.key;
   assign keyoff_now = ~keyon_in & head.key;

   assign slot_wrap = (slot == LAST_SLOT);
   assign zero      = (slot == '0);

   // Head slot index follows the ring rotation and wraps at the last slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          slot <= '0;
      else if (clk_en)  slot <= slot_wrap ? '0 : slot + 1'b1;
   end

   // Count full ring turns; every CNT_DIV turns advance the global counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div    <= '0;
         eg_cnt <= '0;
      end else if (clk_en && slot_wrap) begin
         if (div == DIV_LAST) begin
            div    <= '0;
            eg_cnt <= eg_cnt + 1'b1;
         end else begin
            div <= div + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_jt12_eg_ring.sv
// Bench for the envelope context ring. The reference keeps one context
// record per slot number and a count of enabled cycles since reset.
module tb_jt12_eg_ring;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        keyon_in;
   logic [2:0]  state_next;
   logic [9:0]  pure_eg_in;
   logic        ssg_inv_next;
   logic        ssg_lock_next;
   logic        cnt_lsb;
   logic        keyon_now;
   logic        keyoff_now;
   logic [2:0]  state_in;
   logic [9:0]  eg_in;
   logic        ssg_inv_in;
   logic        ssg_lock_in;
   logic        cnt_in;
   logic [14:0] eg_cnt;
   logic [4:0]  slot;
   logic        zero;

   jt12_eg_ring dut (
      .clk           (clk),
      .rst           (rst),
      .clk_en        (clk_en),
      .keyon_in      (keyon_in),
      .state_next    (state_next),
      .pure_eg_in    (pure_eg_in),
      .ssg_inv_next  (ssg_inv_next),
      .ssg_lock_next (ssg_lock_next),
      .cnt_lsb       (cnt_lsb),
      .keyon_now     (keyon_now),
      .keyoff_now    (keyoff_now),
      .state_in      (state_in),
      .eg_in         (eg_in),
      .ssg_inv_in    (ssg_inv_in),
      .ssg_lock_in   (ssg_lock_in),
      .cnt_in        (cnt_in),
      .eg_cnt        (eg_cnt),
      .slot          (slot),
      .zero          (zero)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: context per slot number, the head slot and enabled-cycle count
   logic [2:0] m_state [24];
   logic [9:0] m_eg    [24];
   logic       m_inv   [24];
   logic       m_lock  [24];
   logic       m_cnt   [24];
   logic       m_key   [24];
   int         m_slot;
   int         m_total;

   function automatic void model_reset();
      for (int i = 0; i < 24; i++) begin
         m_state[i] = 3'b000;
         m_eg[i]    = 10'h3FF;
         m_inv[i]   = 1'b0;
         m_lock[i]  = 1'b0;
         m_cnt[i]   = 1'b0;
         m_key[i]   = 1'b0;
      end
      m_slot  = 0;
      m_total = 0;
   endfunction

   function automatic logic [38:0] expected();
      logic [14:0] ec;
      ec = 15'((m_total / 72) % 32768);
      return {m_state[m_slot], m_eg[m_slot], m_inv[m_slot], m_lock[m_slot],
              m_cnt[m_slot], keyon_in & ~m_key[m_slot],
              ~keyon_in & m_key[m_slot], 5'(m_slot), (m_slot == 0), ec};
   endfunction

   wire [38:0] observed = {state_in, eg_in, ssg_inv_in, ssg_lock_in, cnt_in,
                           keyon_now, keyoff_now, slot, zero, eg_cnt};

   // One clock; on an enabled edge the slot at the head takes the inputs
   task automatic tick(input logic en);
      logic [2:0] s;
      logic [9:0] e;
      logic       i, l, c, k;
      clk_en = en;
      s = state_next; e = pure_eg_in; i = ssg_inv_next;
      l = ssg_lock_next; c = cnt_lsb; k = keyon_in;
      @(posedge clk);
      if (en && !rst) begin
         m_state[m_slot] = (s == 3'b001 || s == 3'b010 || s == 3'b100) ? s : 3'b000;
         m_eg[m_slot]    = e;
         m_inv[m_slot]   = i;
         m_lock[m_slot]  = l;
         m_cnt[m_slot]   = c;
         m_key[m_slot]   = k;
         m_slot  = (m_slot + 1) % 24;
         m_total = m_total + 1;
      end
      #1;
   endtask

   // Feed the head context straight back, with the given key bit
   task automatic set_pass(input logic key);
      state_next    = m_state[m_slot];
      pure_eg_in    = m_eg[m_slot];
      ssg_inv_next  = m_inv[m_slot];
      ssg_lock_next = m_lock[m_slot];
      cnt_lsb       = m_cnt[m_slot];
      keyon_in      = key;
   endtask

   task automatic set_random();
      state_next    = 3'($urandom);
      pure_eg_in    = 10'($urandom);
      ssg_inv_next  = 1'($urandom);
      ssg_lock_next = 1'($urandom);
      cnt_lsb       = 1'($urandom);
      keyon_in      = 1'($urandom);
   endtask

   task automatic pulse_reset();
      #1 rst = 1'b1;
      model_reset();
      #2 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clk_en = 1'b0;
      set_pass(1'b0);
      model_reset();
      #2;
      n_cmp++;
      if (observed !== expected()) begin
         n_bad++; $display("FAIL reset_state got=%h want=%h", observed, expected());
      end
      for (int n = 0; n < 3; n++) begin
         set_random();
         tick(1'($urandom));
         n_cmp++;
         if (observed !== expected()) begin
            n_bad++; $display("FAIL reset_hold got=%h want=%h", observed, expected());
         end
      end
      #2 rst = 1'b0;
      for (int n = 0; n < 24; n++) begin
         set_pass(1'b0);
         #1;
         n_cmp++;
         if ({state_in, eg_in, slot, zero} !== {3'b000, 10'h3FF, 5'(n), (n == 0)}) begin
            n_bad++;
            $display("FAIL reset_heads n=%0d got st=%b eg=%h slot=%0d zero=%b", n, state_in, eg_in, slot, zero);
         end
         n_cmp++;
         if (observed !== expected()) begin
            n_bad++; $display("FAIL reset_ring slot=%0d got=%h want=%h", m_slot, observed, expected());
         end
         tick(1'b1);
      end
   endtask

   task automatic test_keyon();
      int pass;
      pass = 0;
      for (int n = 0; n < 72; n++) begin
         pass = n / 24;
         set_pass((m_slot == 5) && (pass < 2));
         if (m_slot == 5 && pass == 0) state_next = 3'b001;
         #1;
         n_cmp++;
         if ({keyon_now, keyoff_now} !== {(m_slot == 5 && pass == 0), (m_slot == 5 && pass == 2)}) begin
            n_bad++;
            $display("FAIL key_edges pass=%0d slot=%0d got on=%b off=%b", pass, m_slot, keyon_now, keyoff_now);
         end
         if (m_slot == 5 && pass == 1) begin
            n_cmp++;
            if (state_in !== 3'b001) begin
               n_bad++; $display("FAIL keyon_state got=%b want=001", state_in);
            end
         end
         n_cmp++;
         if (observed !== expected()) begin
            n_bad++; $display("FAIL keyon_ring slot=%0d got=%h want=%h", m_slot, observed, expected());
         end
         tick(1'b1);
      end
   endtask

   task automatic test_eg_loop();
      pulse_reset();
      for (int n = 0; n < 2400; n++) begin
         set_pass(1'b0);
         if (m_slot == 3) pure_eg_in = m_eg[3] - 10'd1;
         #1;
         if (n >= 2376) begin
            n_cmp++;
            if (eg_in !== ((m_slot == 3) ? 10'h39C : 10'h3FF)) begin
               n_bad++; $display("FAIL eg_last_pass slot=%0d got=%h", m_slot, eg_in);
            end
         end
         n_cmp++;
         if (observed !== expected()) begin
            n_bad++; $display("FAIL eg_loop slot=%0d got=%h want=%h", m_slot, observed, expected());
         end
         tick(1'b1);
      end
      for (int n = 0; n < 3; n++) begin
         set_pass(1'b0);
         tick(1'b1);
      end
      n_cmp++;
      if ({slot, eg_in} !== {5'd3, 10'h39B}) begin
         n_bad++; $display("FAIL eg_final got slot=%0d eg=%h want slot=3 eg=39B", slot, eg_in);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         set_random();
         #1;
         n_cmp++;
         if (observed !== expected()) begin
            n_bad++; $display("FAIL random n=%0d got=%h want=%h", n, observed, expected());
         end
         tick($urandom_range(0, 9) < 7);
      end
   endtask

   task automatic test_egcnt();
      int guard;
      guard = 0;
      pulse_reset();
      while (m_total < 432 && guard < 2000) begin
         guard++;
         set_pass(1'($urandom));
         #1;
         if (m_total == 431) begin
            n_cmp++;
            if (eg_cnt !== 15'd5) begin
               n_bad++; $display("FAIL egcnt_before got=%0d want=5", eg_cnt);
            end
         end
         n_cmp++;
         if (observed !== expected()) begin
            n_bad++; $display("FAIL egcnt_ring total=%0d got=%h want=%h", m_total, observed, expected());
         end
         tick($urandom_range(0, 3) != 0);
      end
      n_cmp++;
      if (eg_cnt !== 15'd6 || m_total != 432) begin
         n_bad++; $display("FAIL egcnt_after got=%0d want=6 (enabled=%0d)", eg_cnt, m_total);
      end
   endtask

   task automatic test_mid_reset();
      int guard;
      guard = 0;
      for (int n = 0; n < 60; n++) begin
         set_random();
         tick(1'b1);
      end
      while (m_slot != 12 && guard < 48) begin
         guard++;
         set_random();
         tick(1'b1);
      end
      #2 rst = 1'b1;
      keyon_in = 1'b0;
      #1;
      n_cmp++;
      if ({state_in, eg_in, slot, zero, eg_cnt, keyoff_now} !== {3'b000, 10'h3FF, 5'd0, 1'b1, 15'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL midrst_async got st=%b eg=%h slot=%0d zero=%b cnt=%0d", state_in, eg_in, slot, zero, eg_cnt);
      end
      model_reset();
      tick(1'b1);
      #2 rst = 1'b0;
      for (int n = 0; n < 10; n++) begin
         set_random();
         #1;
         n_cmp++;
         if ({state_in, eg_in, slot, zero, keyon_now} !== {3'b000, 10'h3FF, 5'd0, 1'b1, keyon_in}) begin
            n_bad++; $display("FAIL midrst_idle n=%0d got st=%b eg=%h slot=%0d", n, state_in, eg_in, slot);
         end
         n_cmp++;
         if (observed !== expected()) begin
            n_bad++; $display("FAIL midrst_ring got=%h want=%h", observed, expected());
         end
         tick(1'b0);
      end
      for (int n = 0; n < 24; n++) begin
         set_pass(1'b0);
         #1;
         n_cmp++;
         if ({state_in, eg_in, slot} !== {3'b000, 10'h3FF, 5'(n)}) begin
            n_bad++; $display("FAIL midrst_clear n=%0d got st=%b eg=%h slot=%0d", n, state_in, eg_in, slot);
         end
         tick(1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_keyon();
      test_eg_loop();
      test_random();
      test_egcnt();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/jt12_eg_ring.md
Name: jt12_eg_ring

Overview:
- Sequential state holder directly upstream of the combinational envelope stage (jt12_eg_comb).
- Keeps per-operator envelope context for 24 operator slots in a circular shift ring: state, attenuation, SSG inversion/lock, counter LSB and previous key bit.
- Presents the current slot's context to the combinational stage and captures its results back into the ring.
- Generates key-on/key-off edge pulses and the global 15-bit envelope counter.

Parameters:
- SLOTS, 24, number of operator slots in the ring (fixed 24 for YM2612 timing).
- CNT_DIV, 3, samples per eg_cnt increment.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- clk_en  in  1  slot advance enable; ring shifts only when high
- keyon_in  in  1  key bit for the slot currently at the head
- state_next  in  3  next state from the combinational stage
- pure_eg_in  in  10  updated attenuation from the combinational stage
- ssg_inv_next  in  1  SSG inversion result
- ssg_lock_next  in  1  SSG hold result
- cnt_lsb  in  1  counter LSB result from the combinational stage
- keyon_now  out  1  rising-edge key pulse for the head slot
- keyoff_now  out  1  falling-edge key pulse for the head slot
- state_in  out  3  head slot state
- eg_in  out  10  head slot attenuation
- ssg_inv_in  out  1  head slot inversion
- ssg_lock_in  out  1  head slot hold
- cnt_in  out  1  head slot counter LSB
- eg_cnt  out  15  global envelope counter
- slot  out  5  head slot index 0..23
- zero  out  1  high when slot==0

Behaviour:
- State encoding: ATTACK=3'b001, DECAY=3'b010, HOLD=3'b100, RELEASE=3'b000. Other codes are illegal. An illegal state_next is stored as RELEASE.
- Reset, asynchronous:
  - every ring entry: state=RELEASE, eg=10'h3FF, inv=0, lock=0, cnt=0, prev_key=0
  - slot=0, sample divider=0, eg_cnt=0
  - all outputs reflect the reset entry: keyon_now=0, keyoff_now=0, zero=1
- Head outputs are combinational from the head entry and keyon_in:
  - keyon_now = keyon_in & ~prev_key
  - keyoff_now = ~keyon_in & prev_key
- On a clk_en rising edge, the ring shifts one position. The tail receives {state_next, pure_eg_in, ssg_inv_next, ssg_lock_next, cnt_lsb, keyon_in}, and the new head is the next slot's entry.
- Round-trip latency: a slot's results reappear at the head exactly SLOTS clk_en cycles later.
- clk_en low: no register changes. Outputs are held apart from the combinational keyon edge terms.
- slot increments per clk_en and wraps 23→0.
- Sample divider: increments when slot wraps to 0, counting 0..CNT_DIV-1. When the divider wraps, eg_cnt increments.
- eg_cnt wraps 15'h7FFF→0. Value 0 is legal and does not stall the counter.
- keyon_in toggling while clk_en is low: the pulse is only committed (prev_key updated) at the next clk_en edge.
- rst asserted mid-ring: all slots immediately return to RELEASE/3FF. The slot counter restarts at 0.
- Same-edge key-on and key-off for a slot is impossible by construction: prev_key is a single bit.

Decomposition:
- Package jt12_eg_pkg:
  - state localparams ATTACK/DECAY/HOLD/RELEASE
  - EG_SILENT=10'h3FF
  - SLOT_W=5, EGCNT_W=15
  - packed entry typedef {state, eg, inv, lock, cnt, key}, 17 bits
- Sub-module jt12_sh_rst: a parameterised width × depth shift register with asynchronous reset value and clk_en. It holds the 17-bit entry ring.
- Slot, divider and eg_cnt counters stay in the top module.

Test Plan:
- Reset, then read all 24 heads over 24 clk_en → each state_in=000, eg_in=3FF, slot sequence 0..23, zero high only at slot 0.
- keyon_in=1 at slot 5, combinational stage feeding state_next=001 → keyon_now=1 at slot 5. 24 clk_en later at slot 5, state_in=001, keyon_now=0.
- Hold key at slot 5 then drop it → keyoff_now=1 exactly at slot 5 of that pass, and at no other slot.
- Loop back pure_eg_in=eg_in-1 for 100 passes → slot 3 eg_in goes 3FF→39B; other slots are unaffected when fed passthrough.
- Run 3×24×0x8000 clk_en → eg_cnt increments every 72 clk_en and wraps 7FFF→0000.
- Assert rst at slot 12 with nonzero contents, release it, and hold clk_en low for 10 clk → outputs show RELEASE/3FF at slot 0 and nothing changes.
